// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_fb_pkg;

    localparam int ADDR_W_DEF    = 19;
    localparam int DATA_W_DEF    = 6;
    localparam int RD_LAT_DEF    = 2;
    localparam int MAX_BURST_DEF = 8;

    // Last grant taken; drives the RAM strobes one cycle after the grant.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_HOST = 2'd2
    } state_e;

    // 2 bits each of red, green, blue.
    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } pixel_t;

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return tracker: valid shift register plus read-data capture register.
// Latency: rvalid follows issue_vld by RD_LAT+1 cycles; data captured when RAM data is valid.
// Backpressure: none; every issued read returns exactly once, in order.
module fb_rd_pipe
    import vga_fb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_vld,
    input  logic [DATA_W-1:0] rdata_in,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata_out
);

    localparam int DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    // Shift the valid token; grab RAM data in the cycle it is valid (one stage before the end).
    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], issue_vld};
        dat_d = dat_q;
        if (vld_q[RD_LAT-1]) begin
            dat_d = rdata_in;
        end
    end

    // Reset drops all in-flight tokens so pre-reset reads never return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign rvalid    = vld_q[DEPTH-1];
    assign rdata_out = dat_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates display reads and host writes onto one single-port frame-buffer RAM.
// Latency: grant in cycle N -> RAM access in N+1 -> display data valid in N+2+RD_LAT.
// Backpressure: disp_gnt/host_ready (combinational); display bursts bounded by MAX_BURST when host waits.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blank,
    input  logic              disp_req,
    input  logic              disp_urgent,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_e            state_q, state_d;
    logic [7:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Priority arbitration: urgent display, then blanking favours host,
    // then active video favours display unless the host has waited a full burst.
    always_comb begin
        disp_gnt   = 1'b0;
        host_ready = 1'b0;
        if (disp_req && disp_urgent) begin
            disp_gnt = 1'b1;
        end else if (blank) begin
            if (host_valid) begin
                host_ready = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end
        end else if (host_valid && (burst_q == BURST_MAX)) begin
            host_ready = 1'b1;
        end else if (disp_req) begin
            disp_gnt = 1'b1;
        end else if (host_valid) begin
            host_ready = 1'b1;
        end
    end

    // Next state records the grant and latches the access; burst counts display wins over a waiting host.
    always_comb begin
        state_d = ST_IDLE;
        addr_d  = '0;
        wdata_d = '0;
        burst_d = burst_q;
        if (disp_gnt) begin
            state_d = ST_DISP;
            addr_d  = disp_addr;
        end else if (host_ready) begin
            state_d = ST_HOST;
            addr_d  = host_addr;
            wdata_d = host_wdata;
        end
        if (!host_valid || host_ready) begin
            burst_d = '0;
        end else if (disp_gnt && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + 8'd1;
        end
    end

    // State and RAM-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Strobes decode straight from the registered state, so mem_we can never appear without mem_en.
    assign mem_en    = (state_q != ST_IDLE);
    assign mem_we    = (state_q == ST_HOST);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    fb_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_vld (state_q == ST_DISP),
        .rdata_in  (mem_rdata),
        .rvalid    (disp_rvalid),
        .rdata_out (disp_rdata)
    );

endmodule
